// File: rtl/frequency_analyzer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frequency_analyzer_pkg
// Description : Types and constants shared by the frequency-analyzer manager
//               and the result reader.
// Revision    : 1.0 - initial release
// ============================================================================
package frequency_analyzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } reader_state_t;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam int c_REGISTERS_NUMBER = 7;

    // Any response other than OKAY flags the acquisition as suspect.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != c_RESP_OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_handshake_timeout.sv
`default_nettype none
// ============================================================================
// Module      : axi_handshake_timeout
// Description : Load/count/expire counter bounding one AXI handshake phase.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_handshake_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                 c_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WIDTH-1:0] c_LAST  = c_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WIDTH-1:0] c_ONE   = c_WIDTH'(1);

    logic [c_WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_expired = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/frequency_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : frequency_result_reader
// Description : AXI4-Lite read master draining the analyzer result registers
//               into a valid/ready stream on each rising edge of irq.
// Revision    : 1.0 - initial release
// ============================================================================
module frequency_result_reader
    import frequency_analyzer_pkg::*;
#(
    parameter int C_M00_AXI_ADDR_WIDTH = 10,
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int BASE_ADDRESS         = 0,
    parameter int REGISTERS_NUMBER     = c_REGISTERS_NUMBER,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_aresetn,
    input  logic                            irq,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready,
    output logic [31:0]                     result_data,
    output logic [3:0]                      result_index,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam logic [C_M00_AXI_ADDR_WIDTH-1:0] c_BASE       = C_M00_AXI_ADDR_WIDTH'(BASE_ADDRESS);
    localparam logic [C_M00_AXI_ADDR_WIDTH-1:0] c_STEP       = C_M00_AXI_ADDR_WIDTH'(4);
    localparam logic [3:0]                      c_LAST_INDEX = 4'(REGISTERS_NUMBER);

    reader_state_t                   r_state;
    reader_state_t                   w_state_next;
    logic                            r_irq_d;
    logic                            r_trigger;
    logic [3:0]                      r_index;
    logic [C_M00_AXI_ADDR_WIDTH-1:0] r_araddr;
    logic                            r_arvalid;
    logic                            r_rready;
    logic [31:0]                     r_result_data;
    logic [3:0]                      r_result_index;
    logic                            r_result_valid;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_error;
    logic                            w_timeout;
    logic                            w_abort;
    logic                            w_capture;
    logic                            w_emit_accept;

    axi_handshake_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (m00_axi_aclk),
        .i_rst_n   (m00_axi_aresetn),
        .i_load    (w_state_next != r_state),
        .i_enable  ((r_state == ST_ADDR) || (r_state == ST_DATA)),
        .o_expired (w_timeout)
    );

    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_trigger) w_state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (m00_axi_arready) begin
                    w_state_next = ST_DATA;
                end else if (w_timeout) begin
                    w_state_next = ST_FIN;
                    w_abort      = 1'b1;
                end
            end
            ST_DATA: begin
                if (m00_axi_rvalid) begin
                    w_state_next = ST_EMIT;
                end else if (w_timeout) begin
                    w_state_next = ST_FIN;
                    w_abort      = 1'b1;
                end
            end
            ST_EMIT: begin
                if (result_ready) begin
                    w_state_next = (r_index == c_LAST_INDEX) ? ST_FIN : ST_ADDR;
                end
            end
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_capture     = (r_state == ST_DATA) && m00_axi_rvalid;
    assign w_emit_accept = (r_state == ST_EMIT) && result_ready;

    // Handshake outputs are flopped decodes of the next state so every port is registered.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            r_state        <= ST_IDLE;
            r_irq_d        <= 1'b0;
            r_trigger      <= 1'b0;
            r_index        <= 4'd0;
            r_araddr       <= c_BASE;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_result_data  <= 32'd0;
            r_result_index <= 4'd0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_irq_d        <= irq;
            r_trigger      <= irq && !r_irq_d && (r_state == ST_IDLE);
            r_arvalid      <= (w_state_next == ST_ADDR);
            r_rready       <= (w_state_next == ST_DATA);
            r_result_valid <= (w_state_next == ST_EMIT);
            r_done         <= (w_state_next == ST_FIN);
            r_busy         <= (w_state_next != ST_IDLE);

            if ((r_state == ST_IDLE) && r_trigger) begin
                r_index  <= 4'd1;
                r_araddr <= c_BASE;
                r_error  <= 1'b0;
            end

            // The word is forwarded even when the slave flags it as bad.
            if (w_capture) begin
                r_result_data  <= m00_axi_rdata[31:0];
                r_result_index <= r_index;
                if (resp_is_error(m00_axi_rresp)) r_error <= 1'b1;
            end

            if (w_abort) r_error <= 1'b1;

            if (w_emit_accept && (r_index != c_LAST_INDEX)) begin
                r_index  <= r_index + 4'd1;
                r_araddr <= r_araddr + c_STEP;
            end
        end
    end

    assign m00_axi_araddr  = r_araddr;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = r_arvalid;
    assign m00_axi_rready  = r_rready;
    assign result_data     = r_result_data;
    assign result_index    = r_result_index;
    assign result_valid    = r_result_valid;
    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_frequency_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_frequency_result_reader
// Description : Self-checking bench: AXI slave model, result sink, scenario
//               table and randomized bursts against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frequency_result_reader;
    import frequency_analyzer_pkg::*;

    localparam int c_N       = 7;
    localparam int c_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        irq;
    logic [9:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] result_data;
    logic [3:0]  result_index;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    frequency_result_reader #(
        .C_M00_AXI_ADDR_WIDTH (10),
        .C_M00_AXI_DATA_WIDTH (32),
        .BASE_ADDRESS         (0),
        .REGISTERS_NUMBER     (c_N),
        .TIMEOUT_CYCLES       (c_TIMEOUT)
    ) dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (aresetn),
        .irq             (irq),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready),
        .result_data     (result_data),
        .result_index    (result_index),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    typedef struct {
        int ar_delay;
        int r_delay;
        int err_reg;
        int hang_reg;
        int stall_idx;
        int stall_len;
        int exp_lat;
        int exp_drop;
    } scen_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cyc_irq;

    // Slave / sink configuration
    int ar_d [16];
    int r_d  [16];
    int err_reg, hang_reg, stall_idx, stall_len, stall_left;
    bit random_ready;

    // Observations collected by the bus process
    logic [35:0] res_log[$];
    logic [9:0]  ar_log[$];
    int first_ar_cyc, drop_len, viol;

    // Bus-process private state
    bit          last_arvalid, last_rready, last_res_valid, last_res_ready;
    logic [9:0]  last_araddr;
    logic [31:0] last_data;
    logic [3:0]  last_idx;
    bit          hs_ar, hs_r, s_pending;
    int          ar_wait, r_wait, s_k, k_now, ar_run;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // AXI slave, result sink and protocol monitor, all acting on the falling edge.
    initial begin
        arready      = 1'b0;
        rvalid       = 1'b0;
        rdata        = '0;
        rresp        = c_RESP_OKAY;
        result_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                arready = 1'b0; rvalid = 1'b0; s_pending = 1'b0;
                ar_wait = 0; r_wait = 0; ar_run = 0;
                last_arvalid = 1'b0; last_rready = 1'b0;
                last_res_valid = 1'b0; last_res_ready = 1'b0;
            end else begin
                hs_ar = last_arvalid && arready;
                hs_r  = last_rready && rvalid;
                if (hs_r) rvalid = 1'b0;
                if (hs_ar) begin
                    arready   = 1'b0;
                    ar_wait   = 0;
                    ar_log.push_back(last_araddr);
                    s_k       = int'(last_araddr) / 4 + 1;
                    s_pending = 1'b1;
                    r_wait    = 0;
                end
                if (s_pending) begin
                    if (r_wait >= r_d[s_k]) begin
                        rvalid    = 1'b1;
                        rdata     = 32'(100 + s_k);
                        rresp     = (s_k == err_reg) ? c_RESP_SLVERR : c_RESP_OKAY;
                        s_pending = 1'b0;
                    end else begin
                        r_wait++;
                    end
                end
                if (arvalid && !arready) begin
                    k_now = int'(araddr) / 4 + 1;
                    if (k_now != hang_reg) begin
                        if (ar_wait >= ar_d[k_now]) arready = 1'b1;
                        else ar_wait++;
                    end
                end else if (!arvalid) begin
                    ar_wait = 0;
                end

                if (arvalid) begin
                    if (first_ar_cyc < 0) first_ar_cyc = cyc;
                    if (last_arvalid && !hs_ar) begin
                        if (araddr != last_araddr) viol++;
                        ar_run++;
                    end else begin
                        ar_run = 1;
                    end
                    if (result_valid) viol++;
                end else if (last_arvalid && !hs_ar) begin
                    drop_len = ar_run;
                end

                if (random_ready) result_ready = ($urandom_range(0, 3) != 0);
                else if (result_valid && int'(result_index) == stall_idx && stall_left > 0) begin
                    result_ready = 1'b0;
                    stall_left--;
                end else result_ready = 1'b1;

                if (last_res_valid && !last_res_ready) begin
                    if (!result_valid) viol++;
                    else if (result_data != last_data || result_index != last_idx) viol++;
                end
                if (result_valid && result_ready) res_log.push_back({result_index, result_data});

                last_arvalid   = arvalid;
                last_araddr    = araddr;
                last_rready    = rready;
                last_res_valid = result_valid;
                last_res_ready = result_ready;
                last_data      = result_data;
                last_idx       = result_index;
            end
        end
    end

    // One acquisition: expected words, addresses and error come from the register-level rules.
    task automatic run_burst(input int exp_lat, input int exp_drop);
        logic [35:0] exp_res[$];
        logic [9:0]  exp_ar[$];
        bit          exp_err;
        bit          got_done;
        int          lat;
        exp_err = 1'b0;
        for (int k = 1; k <= c_N; k++) begin
            if (k == hang_reg) begin
                exp_err = 1'b1;
                break;
            end
            exp_ar.push_back(10'(4 * (k - 1)));
            exp_res.push_back({4'(k), 32'(100 + k)});
            if (k == err_reg) exp_err = 1'b1;
        end
        res_log.delete();
        ar_log.delete();
        first_ar_cyc = -1;
        drop_len     = 0;
        viol         = 0;
        stall_left   = stall_len;

        @(negedge clk);
        irq     = 1'b1;
        cyc_irq = cyc;
        @(negedge clk);
        irq = 1'b0;
        @(negedge clk);
        check("start_error_cleared", error, 0);
        check("start_busy", busy, 1);

        got_done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        check("done_seen", got_done, 1);
        lat = cyc - cyc_irq;
        if (exp_lat >= 0) check("done_latency", lat, exp_lat);
        check("first_arvalid_delay", first_ar_cyc - cyc_irq, 2);
        check("busy_at_done", busy, 1);
        check("error_at_done", error, exp_err);
        check("result_count", res_log.size(), exp_res.size());
        for (int i = 0; i < exp_res.size() && i < res_log.size(); i++) begin
            check("result_index", res_log[i][35:32], exp_res[i][35:32]);
            check("result_data", res_log[i][31:0], exp_res[i][31:0]);
        end
        check("araddr_count", ar_log.size(), exp_ar.size());
        for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
            check("araddr", ar_log[i], exp_ar[i]);
        check("arvalid_drop_len", drop_len, exp_drop);
        check("protocol_violations", viol, 0);
        @(negedge clk);
        check("done_is_pulse", done, 0);
        check("busy_after_done", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic set_delays(input int ad, input int rd);
        for (int k = 0; k < 16; k++) begin
            ar_d[k] = ad;
            r_d[k]  = rd;
        end
    endtask

    initial begin
        scen_t tbl[5];
        bit    got;
        tbl[0] = '{0, 0, 0, 0, 0, 0, 23, 0};
        tbl[1] = '{3, 2, 0, 0, 0, 0, 58, 0};
        tbl[2] = '{0, 0, 0, 0, 4, 10, 33, 0};
        tbl[3] = '{0, 0, 3, 0, 0, 0, 23, 0};
        tbl[4] = '{0, 0, 0, 5, 0, 0, 30, c_TIMEOUT};

        aresetn = 1'b0;
        irq     = 1'b0;
        random_ready = 1'b0;
        err_reg = 0; hang_reg = 0; stall_idx = 0; stall_len = 0; stall_left = 0;
        first_ar_cyc = -1; drop_len = 0; viol = 0;
        set_delays(0, 0);

        repeat (3) @(negedge clk);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_araddr", araddr, 0);
        check("rst_result_data", result_data, 0);
        check("rst_result_index", result_index, 0);
        check("arprot", arprot, 0);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int s = 0; s < 5; s++) begin
            set_delays(tbl[s].ar_delay, tbl[s].r_delay);
            err_reg   = tbl[s].err_reg;
            hang_reg  = tbl[s].hang_reg;
            stall_idx = tbl[s].stall_idx;
            stall_len = tbl[s].stall_len;
            run_burst(tbl[s].exp_lat, tbl[s].exp_drop);
        end

        // Randomized slave latencies, error placement and sink backpressure
        hang_reg = 0; stall_idx = 0; stall_len = 0;
        random_ready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 16; k++) begin
                ar_d[k] = $urandom_range(0, 3);
                r_d[k]  = $urandom_range(0, 3);
            end
            err_reg = $urandom_range(0, c_N);
            run_burst(-1, 0);
        end
        random_ready = 1'b0;

        // Reset in the data phase of register 2
        set_delays(0, 3);
        err_reg = 1;
        res_log.delete();
        ar_log.delete();
        @(negedge clk);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rready && ar_log.size() == 2) begin
                got = 1'b1;
                break;
            end
        end
        check("reached_data_reg2", got, 1);
        check("error_before_reset", error, 1);
        #2 aresetn = 1'b0;
        #1;
        check("async_rst_arvalid", arvalid, 0);
        check("async_rst_rready", rready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_error", error, 0);
        check("async_rst_result_valid", result_valid, 0);
        check("async_rst_done", done, 0);
        check("async_rst_araddr", araddr, 0);
        check("async_rst_result_data", result_data, 0);
        check("async_rst_result_index", result_index, 0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        set_delays(0, 0);
        err_reg = 0;
        run_burst(23, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
